pcie_tag_alloc: RTL

- Free-list allocator for PCIe non-posted request tags (up to 32).
- Holds a free bitmap and offers the highest-numbered free tag to the read-request TLP builder over a valid/ready handshake.
- Reclaims tags from the completion path.
- Sits directly upstream of the request generator; it is the consumer of the clz priority encoder, which selects the offered tag.

---
 rtl/pcie_tag_alloc_pkg.sv | 29 ++
 rtl/pcie_tag_alloc_if.sv | 28 ++
 rtl/pcie_tag_alloc_clz.sv | 24 ++
 rtl/pcie_tag_alloc.sv | 102 ++++++++++
 4 files changed

// File: rtl/pcie_tag_alloc_pkg.sv
// Shared constants, types and helpers for the PCIe non-posted tag allocator.
package pcie_tag_pkg;

  localparam int unsigned TAG_BITS_DEF  = 5;
  localparam int unsigned NUM_TAGS_DEF  = 32;
  localparam int unsigned TAG_SPACE_MAX = 32;

  typedef enum logic [1:0] {
    REL_NONE,
    REL_OK,
    REL_ERR
  } rel_kind_e;

  function automatic logic [TAG_SPACE_MAX-1:0] onehot(input logic [4:0] tag);
    return {{(TAG_SPACE_MAX-1){1'b0}}, 1'b1} << tag;
  endfunction

  function automatic logic [TAG_SPACE_MAX-1:0] valid_mask(input int unsigned num_tags);
    logic [TAG_SPACE_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < TAG_SPACE_MAX; i++) begin
      m[i] = (i < num_tags);
    end
    return m;
  endfunction

  localparam logic [TAG_SPACE_MAX-1:0] VALID_MASK = valid_mask(NUM_TAGS_DEF);

endpackage

// File: rtl/pcie_tag_alloc_if.sv
// Allocation / release / status bundle between the tag allocator and its neighbours.
interface pcie_tag_alloc_if
  import pcie_tag_pkg::*;
#(
  parameter int unsigned TAG_BITS = TAG_BITS_DEF
) ();

  logic [TAG_BITS:0]   cfg_max_tags;
  logic                alloc_valid;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                alloc_ready;
  logic                rel_valid;
  logic [TAG_BITS-1:0] rel_tag;
  logic [TAG_BITS:0]   outstanding;
  logic                all_free;
  logic                err_double_free;

  modport master (
    input  cfg_max_tags, alloc_ready, rel_valid, rel_tag,
    output alloc_valid, alloc_tag, outstanding, all_free, err_double_free
  );

  modport slave (
    output cfg_max_tags, alloc_ready, rel_valid, rel_tag,
    input  alloc_valid, alloc_tag, outstanding, all_free, err_double_free
  );

endinterface

// File: rtl/pcie_tag_alloc_clz.sv
// Count-leading-zeros priority encoder over a 2**B_WIDTH vector; count_nvalid flags all-zero input.
module pcie_tag_alloc_clz #(
  parameter int unsigned B_WIDTH = 5
) (
  input  logic [(1<<B_WIDTH)-1:0] vec,
  output logic [B_WIDTH-1:0]      count,
  output logic                    count_nvalid
);

  localparam int unsigned W = 1 << B_WIDTH;

  always_comb begin
    count        = '1;
    count_nvalid = 1'b1;
    // Ascending scan: the highest set bit is the last one to write.
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i]) begin
        count        = B_WIDTH'(W - 1 - i);
        count_nvalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcie_tag_alloc.sv
// Free-list allocator for PCIe non-posted tags: offers the highest free tag, reclaims completed ones.
module pcie_tag_alloc
  import pcie_tag_pkg::*;
#(
  parameter int unsigned TAG_BITS = TAG_BITS_DEF,
  parameter int unsigned NUM_TAGS = NUM_TAGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pcie_tag_alloc_if.master  bus
);

  localparam int unsigned SPACE = 1 << TAG_BITS;
  localparam logic [TAG_SPACE_MAX-1:0] VMASK_FULL = valid_mask(NUM_TAGS);
  localparam logic [SPACE-1:0]         VMASK      = VMASK_FULL[SPACE-1:0];
  localparam logic [TAG_BITS:0]        OUT_ONE    = 1;

  logic [SPACE-1:0]    free, free_next;
  logic [TAG_BITS-1:0] cand_tag;
  logic                cand_ok;
  logic                lim_ok;
  logic [TAG_BITS:0]   outstanding, out_next;
  logic                err;

  logic                alloc_valid, alloc;
  rel_kind_e           rel_kind;
  logic                rel_ok;
  logic [TAG_SPACE_MAX-1:0] oh_alloc_full, oh_rel_full;
  logic [TAG_BITS-1:0] clz_count;
  logic                clz_nvalid;

  assign alloc_valid = cand_ok & lim_ok;
  assign alloc       = alloc_valid & bus.alloc_ready;

  always_comb begin
    rel_kind = REL_NONE;
    if (bus.rel_valid) begin
      rel_kind = (VMASK[bus.rel_tag] && !free[bus.rel_tag]) ? REL_OK : REL_ERR;
    end
  end

  assign rel_ok = (rel_kind == REL_OK);

  always_comb begin
    oh_alloc_full = onehot(5'(cand_tag));
    oh_rel_full   = onehot(5'(bus.rel_tag));
    free_next     = free;
    if (alloc)  free_next = free_next & ~oh_alloc_full[SPACE-1:0];
    if (rel_ok) free_next = free_next | oh_rel_full[SPACE-1:0];
  end

  always_comb begin
    out_next = outstanding;
    case ({alloc, rel_ok})
      2'b10:   out_next = outstanding + OUT_ONE;
      2'b01:   out_next = outstanding - OUT_ONE;
      default: out_next = outstanding;
    endcase
  end

  pcie_tag_alloc_clz #(
    .B_WIDTH (TAG_BITS)
  ) u_clz (
    .vec          (free_next),
    .count        (clz_count),
    .count_nvalid (clz_nvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      free        <= VMASK;
      cand_tag    <= '0;
      cand_ok     <= 1'b0;
      lim_ok      <= 1'b0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      free        <= free_next;
      cand_ok     <= ~clz_nvalid;
      // Freeze a pending offer so a higher-numbered release cannot swap the tag under the consumer.
      if (!clz_nvalid && !(alloc_valid && !bus.alloc_ready)) begin
        cand_tag <= ~clz_count;
      end
      lim_ok      <= (out_next < bus.cfg_max_tags);
      outstanding <= out_next;
      if (rel_kind == REL_ERR) err <= 1'b1;
    end
  end

  assign bus.alloc_valid     = alloc_valid;
  assign bus.alloc_tag       = cand_tag;
  assign bus.outstanding     = outstanding;
  assign bus.all_free        = (outstanding == '0);
  assign bus.err_double_free = err;

  a_offer_is_free: assert property (@(posedge clk) disable iff (rst)
    alloc_valid |-> free[cand_tag]);

  a_count_matches: assert property (@(posedge clk) disable iff (rst)
    $countones(~free & VMASK) == int'(outstanding));

endmodule
